branch_target_buffer: RTL and testbench



---
 rtl/branch_target_buffer_pkg.sv | 28 ++
 rtl/branch_target_buffer_sat_counter2.sv | 20 ++
 rtl/branch_target_buffer.sv | 145 ++++++++++++++
 tb/tb_branch_target_buffer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_target_buffer_pkg.sv
// Shared definitions for the branch target buffer: direction counter
// encodings and address index/tag extraction helpers.
package branch_target_buffer_pkg;

   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } ctr_e;

   // Value left in every counter after reset/flush, and the value a freshly
   // allocated (taken) branch starts with.
   localparam ctr_e CTR_INIT  = CTR_WNT;
   localparam ctr_e CTR_ALLOC = CTR_WT;

   // Table index of a word address, zero-extended to 32 bits so callers can
   // compare it against an entry number without slicing.
   function automatic logic [31:0] addr_index(input logic [31:0] addr, input int idx_bits);
      return (addr >> 2) & ((32'd1 << idx_bits) - 32'd1);
   endfunction

   // Tag of an address, right-aligned and zero-extended to 32 bits.
   function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int idx_bits);
      return addr >> (idx_bits + 2);
   endfunction

endpackage

// File: rtl/branch_target_buffer_sat_counter2.sv
// 2-bit saturating direction counter next-state function.
module branch_target_buffer_sat_counter2
   import branch_target_buffer_pkg::*;
(
   input  logic [1:0] ctr_i,
   input  logic       taken_i,
   output logic [1:0] ctr_next_o
);

   // Count up on taken, down on not-taken, holding at both ends.
   always_comb begin
      ctr_next_o = ctr_i;
      if (taken_i) begin
         if (ctr_i != CTR_ST) ctr_next_o = ctr_i + 2'd1;
      end else begin
         if (ctr_i != CTR_SNT) ctr_next_o = ctr_i - 2'd1;
      end
   end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Lookup of PC is purely combinational; training from resolved branches
// takes effect at the next clock edge (no same-cycle bypass).
module branch_target_buffer
   import branch_target_buffer_pkg::*;
#(
   parameter int ENTRIES = 16
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic [31:0] PC,
   output logic        Hit,
   output logic        Pred_Taken,
   output logic [31:0] Pred_Target,
   output logic [31:0] PC_Next_Pred,
   input  logic        Flush,
   input  logic        Update_En,
   input  logic [31:0] Update_PC,
   input  logic        Update_Taken,
   input  logic [31:0] Update_Target
);

   localparam int IDX_BITS = $clog2(ENTRIES);
   localparam int TAG_BITS = 30 - IDX_BITS;

   logic [ENTRIES-1:0]  valid_q, valid_d;
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [TAG_BITS-1:0] tag_d    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];
   logic [31:0]         target_d [ENTRIES];
   logic [1:0]          ctr_q    [ENTRIES];
   logic [1:0]          ctr_d    [ENTRIES];

   logic [31:0]         pc_idx, pc_tag;
   logic                rd_valid;
   logic [TAG_BITS-1:0] rd_tag;
   logic [31:0]         rd_target;
   logic [1:0]          rd_ctr;

   logic [31:0]         up_idx, up_tag;
   logic                up_valid;
   logic [TAG_BITS-1:0] up_entry_tag;
   logic [1:0]          up_ctr;
   logic                up_hit;
   logic [1:0]          up_ctr_next;

   assign pc_idx = addr_index(PC, IDX_BITS);
   assign pc_tag = addr_tag(PC, IDX_BITS);
   assign up_idx = addr_index(Update_PC, IDX_BITS);
   assign up_tag = addr_tag(Update_PC, IDX_BITS);

   // Read port for the fetch lookup: select the entry addressed by PC.
   always_comb begin
      rd_valid  = 1'b0;
      rd_tag    = '0;
      rd_target = '0;
      rd_ctr    = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (pc_idx == 32'(i)) begin
            rd_valid  = valid_q[i];
            rd_tag    = tag_q[i];
            rd_target = target_q[i];
            rd_ctr    = ctr_q[i];
         end
      end
   end

   // Prediction outputs; the target is gated by Hit so stale or never-written
   // entries cannot leak onto the next-address mux.
   always_comb begin
      Hit          = rd_valid && (32'(rd_tag) == pc_tag);
      Pred_Taken   = Hit && rd_ctr[1];
      Pred_Target  = Hit ? rd_target : 32'd0;
      PC_Next_Pred = Pred_Taken ? Pred_Target : (PC + 32'd4);
   end

   // Read port for training: the entry addressed by the resolved branch.
   always_comb begin
      up_valid     = 1'b0;
      up_entry_tag = '0;
      up_ctr       = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (up_idx == 32'(i)) begin
            up_valid     = valid_q[i];
            up_entry_tag = tag_q[i];
            up_ctr       = ctr_q[i];
         end
      end
      up_hit = up_valid && (32'(up_entry_tag) == up_tag);
   end

   branch_target_buffer_sat_counter2 u_sat_counter2 (
      .ctr_i      (up_ctr),
      .taken_i    (Update_Taken),
      .ctr_next_o (up_ctr_next)
   );

   // Table next state: flush wipes everything; otherwise a hit trains the
   // counter (and target if taken), a taken miss allocates, a not-taken miss
   // leaves the table untouched.
   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (Flush) begin
         valid_d = '0;
         for (int i = 0; i < ENTRIES; i++) ctr_d[i] = CTR_INIT;
      end else if (Update_En) begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (up_idx == 32'(i)) begin
               if (up_hit) begin
                  ctr_d[i] = up_ctr_next;
                  if (Update_Taken) target_d[i] = Update_Target;
               end else if (Update_Taken) begin
                  valid_d[i]  = 1'b1;
                  tag_d[i]    = Update_PC[31:IDX_BITS+2];
                  target_d[i] = Update_Target;
                  ctr_d[i]    = CTR_ALLOC;
               end
            end
         end
      end
   end

   // Valid bits and counters carry reset state; reset overrides flush/update.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT;
      end else begin
         valid_q <= valid_d;
         ctr_q   <= ctr_d;
      end
   end

   // Tags and targets are qualified by valid, so they need no reset.
   always_ff @(posedge CLK) begin
      if (!Reset) begin
         tag_q    <= tag_d;
         target_q <= target_d;
      end
   end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer (ENTRIES = 16).
module tb_branch_target_buffer;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic        hit;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic [31:0] pc_next_pred;
   logic        flush;
   logic        upd_en;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference table: plain arrays indexed by entry number.
   bit          m_valid  [16];
   logic [31:0] m_tag    [16];
   logic [31:0] m_target [16];
   int          m_ctr    [16];

   branch_target_buffer #(.ENTRIES(16)) dut (
      .CLK           (clk),
      .Reset         (rst),
      .PC            (pc),
      .Hit           (hit),
      .Pred_Taken    (pred_taken),
      .Pred_Target   (pred_target),
      .PC_Next_Pred  (pc_next_pred),
      .Flush         (flush),
      .Update_En     (upd_en),
      .Update_PC     (upd_pc),
      .Update_Taken  (upd_taken),
      .Update_Target (upd_target)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void model_lookup(input logic [31:0] a, output logic e_hit,
                                        output logic e_pt, output logic [31:0] e_tgt,
                                        output logic [31:0] e_nxt);
      int idx;
      idx   = int'((a / 4) % 16);
      e_hit = m_valid[idx] && (m_tag[idx] == a / 64);
      e_pt  = e_hit && (m_ctr[idx] >= 2);
      e_tgt = e_hit ? m_target[idx] : 32'd0;
      e_nxt = e_pt ? e_tgt : 32'(a + 32'd4);
   endfunction

   function automatic void model_edge(input bit r, input bit f, input bit en,
                                      input logic [31:0] a, input bit tk,
                                      input logic [31:0] tgt);
      int idx;
      if (r || f) begin
         for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 1;
         end
      end else if (en) begin
         idx = int'((a / 4) % 16);
         if (m_valid[idx] && m_tag[idx] == a / 64) begin
            if (tk) begin
               m_ctr[idx]    = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
               m_target[idx] = tgt;
            end else begin
               m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
            end
         end else if (tk) begin
            m_valid[idx]  = 1;
            m_tag[idx]    = a / 64;
            m_target[idx] = tgt;
            m_ctr[idx]    = 2;
         end
      end
   endfunction

   // Apply one clock edge with the given control inputs, mirror it in the
   // model, then return the controls to idle just after the edge.
   task automatic edge_cycle(input bit r, input bit f, input bit en,
                             input logic [31:0] a, input bit tk, input logic [31:0] tgt);
      rst        = r;
      flush      = f;
      upd_en     = en;
      upd_pc     = a;
      upd_taken  = tk;
      upd_target = tgt;
      @(posedge clk);
      model_edge(r, f, en, a, tk, tgt);
      #1;
      rst    = 1'b0;
      flush  = 1'b0;
      upd_en = 1'b0;
   endtask

   task automatic test_reset;
      edge_cycle(1, 0, 0, 32'h0, 0, 32'h0);
      pc = 32'h0000_0100;
      #1;
      n_checks++;
      if (hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b want 0", hit); end
      n_checks++;
      if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred_taken: got %b want 0", pred_taken); end
      n_checks++;
      if (pred_target !== 32'h0) begin n_fail++; $display("FAIL reset_pred_target: got %h want 0", pred_target); end
      n_checks++;
      if (pc_next_pred !== 32'h0000_0104) begin n_fail++; $display("FAIL reset_next: got %h want 00000104", pc_next_pred); end
   endtask

   task automatic test_wrap;
      pc = 32'hFFFF_FFFC;
      #1;
      n_checks++;
      if (pc_next_pred !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_next: got %h want 00000000", pc_next_pred); end
   endtask

   task automatic test_alloc;
      pc         = 32'h20;
      upd_en     = 1'b1;
      upd_pc     = 32'h20;
      upd_taken  = 1'b1;
      upd_target = 32'h80;
      #1;
      n_checks++;
      if (hit !== 1'b0) begin n_fail++; $display("FAIL alloc_same_cycle_hit: got %b want 0", hit); end
      edge_cycle(0, 0, 1, 32'h20, 1, 32'h80);
      pc = 32'h20;
      #1;
      n_checks++;
      if (hit !== 1'b1) begin n_fail++; $display("FAIL alloc_hit: got %b want 1", hit); end
      n_checks++;
      if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL alloc_pred_taken: got %b want 1", pred_taken); end
      n_checks++;
      if (pc_next_pred !== 32'h80) begin n_fail++; $display("FAIL alloc_next: got %h want 00000080", pc_next_pred); end
   endtask

   task automatic test_alias;
      pc = 32'h60;
      #1;
      n_checks++;
      if (hit !== 1'b0) begin n_fail++; $display("FAIL alias_hit: got %b want 0", hit); end
      n_checks++;
      if (pc_next_pred !== 32'h64) begin n_fail++; $display("FAIL alias_next: got %h want 00000064", pc_next_pred); end
      edge_cycle(0, 0, 1, 32'h60, 1, 32'h200);
      pc = 32'h20;
      #1;
      n_checks++;
      if (hit !== 1'b0) begin n_fail++; $display("FAIL alias_evicted_hit: got %b want 0", hit); end
      pc = 32'h60;
      #1;
      n_checks++;
      if (hit !== 1'b1) begin n_fail++; $display("FAIL alias_new_hit: got %b want 1", hit); end
      n_checks++;
      if (pc_next_pred !== 32'h200) begin n_fail++; $display("FAIL alias_new_next: got %h want 00000200", pc_next_pred); end
   endtask

   task automatic test_saturation;
      logic [31:0] exp_next [5];
      bit          exp_pt   [5];
      bit          tk       [5];
      tk       = '{0, 0, 0, 1, 1};
      exp_pt   = '{0, 0, 0, 0, 1};
      exp_next = '{32'h24, 32'h24, 32'h24, 32'h24, 32'h80};
      edge_cycle(0, 0, 1, 32'h20, 1, 32'h80);
      for (int s = 0; s < 5; s++) begin
         edge_cycle(0, 0, 1, 32'h20, tk[s], 32'h80);
         pc = 32'h20;
         #1;
         n_checks++;
         if (hit !== 1'b1) begin n_fail++; $display("FAIL sat_hit step %0d: got %b want 1", s, hit); end
         n_checks++;
         if (pred_taken !== exp_pt[s]) begin n_fail++; $display("FAIL sat_pred_taken step %0d: got %b want %b", s, pred_taken, exp_pt[s]); end
         n_checks++;
         if (pc_next_pred !== exp_next[s]) begin n_fail++; $display("FAIL sat_next step %0d: got %h want %h", s, pc_next_pred, exp_next[s]); end
      end
   endtask

   task automatic test_nt_miss;
      edge_cycle(0, 0, 1, 32'h40, 0, 32'h400);
      pc = 32'h40;
      #1;
      n_checks++;
      if (hit !== 1'b0) begin n_fail++; $display("FAIL nt_miss_hit: got %b want 0", hit); end
      n_checks++;
      if (pc_next_pred !== 32'h44) begin n_fail++; $display("FAIL nt_miss_next: got %h want 00000044", pc_next_pred); end
   endtask

   task automatic test_clear(input bit use_reset);
      logic [31:0] probe [3];
      probe = '{32'h30, 32'h20, 32'h60};
      edge_cycle(0, 0, 1, 32'h20, 1, 32'h80);
      edge_cycle(0, 0, 1, 32'h60, 1, 32'h200);
      edge_cycle(use_reset, !use_reset, 1, 32'h30, 1, 32'h300);
      for (int p = 0; p < 3; p++) begin
         pc = probe[p];
         #1;
         n_checks++;
         if (hit !== 1'b0) begin n_fail++; $display("FAIL clear_hit (reset=%0d) pc %h: got %b want 0", use_reset, pc, hit); end
         n_checks++;
         if (pc_next_pred !== probe[p] + 32'd4) begin n_fail++; $display("FAIL clear_next (reset=%0d) pc %h: got %h want %h", use_reset, pc, pc_next_pred, probe[p] + 32'd4); end
      end
   endtask

   task automatic test_random;
      logic        e_hit, e_pt;
      logic [31:0] e_tgt, e_nxt, a, t;
      bit          r, f, en, tk;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 9) == 0) pc = $urandom;
         else pc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
         a  = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
         t  = $urandom;
         en = ($urandom_range(0, 9) < 6);
         tk = ($urandom_range(0, 2) != 0);
         f  = ($urandom_range(0, 49) == 0);
         r  = ($urandom_range(0, 99) == 0);
         rst = r; flush = f; upd_en = en; upd_pc = a; upd_taken = tk; upd_target = t;
         #1;
         model_lookup(pc, e_hit, e_pt, e_tgt, e_nxt);
         n_checks++;
         if (hit !== e_hit) begin n_fail++; $display("FAIL rnd_hit cyc %0d pc %h: got %b want %b", c, pc, hit, e_hit); end
         n_checks++;
         if (pred_taken !== e_pt) begin n_fail++; $display("FAIL rnd_pred_taken cyc %0d pc %h: got %b want %b", c, pc, pred_taken, e_pt); end
         n_checks++;
         if (pred_target !== e_tgt) begin n_fail++; $display("FAIL rnd_pred_target cyc %0d pc %h: got %h want %h", c, pc, pred_target, e_tgt); end
         n_checks++;
         if (pc_next_pred !== e_nxt) begin n_fail++; $display("FAIL rnd_next cyc %0d pc %h: got %h want %h", c, pc, pc_next_pred, e_nxt); end
         edge_cycle(r, f, en, a, tk, t);
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; upd_en = 1'b0; upd_pc = '0;
      upd_taken = 1'b0; upd_target = '0; pc = '0;
      test_reset();
      test_wrap();
      test_alloc();
      test_alias();
      test_saturation();
      test_nt_miss();
      test_clear(1'b0);
      test_clear(1'b1);
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
